// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, req/ack imem fetch, next-PC select.
// Optional IFU_ALIGN_CHECK_EN traps misaligned next PCs into a sticky FAULT state.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic        instr_valid,
  input  logic        instr_done,
  input  logic        branch,
  input  logic        zero,
  input  logic        jal,
  input  logic        jr,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault
);

  typedef enum logic [1:0] {IDLE, REQ, VALID, FAULT} state_t;

  state_t      state;
  logic [31:0] sel_pc;
  logic [31:0] next_pc;

  assign imem_addr = pc;
  assign opcode    = instr[31:26];
  assign func      = instr[5:0];
  assign pc_plus4  = pc + 32'd4;

  // jr must beat jal: control raises both for a jr instruction
  always_comb begin
    sel_pc = pc_plus4;
    if (jr)
      sel_pc = rs_data;
    else if (jal)
      sel_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (branch && zero)
      sel_pc = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
  end

`ifdef IFU_ALIGN_CHECK_EN
  assign next_pc = sel_pc;
`else
  assign next_pc = sel_pc & 32'hFFFF_FFFC;
  assign fault   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
      fault       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= VALID;
          end
        end
        VALID: begin
          if (instr_done) begin
            instr_valid <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
            if (next_pc[1:0] != 2'b00) begin
              state <= FAULT;
              fault <= 1'b1;
            end else
`endif
            begin
              pc       <= next_pc;
              imem_req <= 1'b1;
              state    <= REQ;
            end
          end
        end
        FAULT: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (define IFU_ALIGN_CHECK_EN to match a fault-enabled build).
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        instr_valid;
  logic        instr_done;
  logic        branch;
  logic        zero;
  logic        jal;
  logic        jr;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .instr(instr),
    .opcode(opcode), .func(func), .instr_valid(instr_valid),
    .instr_done(instr_done), .branch(branch), .zero(zero), .jal(jal),
    .jr(jr), .rs_data(rs_data), .pc(pc), .pc_plus4(pc_plus4), .fault(fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, then return a zero-wait ack.
  task automatic fetch(input logic [31:0] word);
    int n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    check("req_wait", {31'd0, imem_req}, 32'd1);
    imem_rdata = word;
    imem_ack   = 1'b1;
    tick();
    imem_ack   = 1'b0;
    check("valid_after_ack", {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic retire(input logic b, input logic z, input logic j, input logic r,
                        input logic [31:0] rs);
    branch = b; zero = z; jal = j; jr = r; rs_data = rs;
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    branch = 1'b0; zero = 1'b0; jal = 1'b0; jr = 1'b0; rs_data = '0;
  endtask

  initial begin
    int cnt;
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_done = 1'b0;
    branch = 1'b0; zero = 1'b0; jal = 1'b0; jr = 1'b0; rs_data = '0;
    tick(); tick();
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_instr", instr, 32'h0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    rst = 1'b0;

    // lui at reset PC, sequential retire
    fetch(32'h3C01_1234);
    check("addr0", imem_addr, 32'h0000_3000);
    check("opcode_lui", {26'd0, opcode}, 32'h0F);
    check("func_lui", {26'd0, func}, 32'h34);
    imem_rdata = 32'hDEAD_BEEF;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("ack_in_valid_ignored", instr, 32'h3C01_1234);
    retire(0, 0, 0, 0, 32'h0);
    check("seq_pc", pc, 32'h0000_3004);
    check("valid_drop", {31'd0, instr_valid}, 32'd0);
    check("req_after_done", {31'd0, imem_req}, 32'd1);

    // jr priority over jal: word is a j to 0x3010, target must be rs_data
    fetch(32'h0800_0C04);
    retire(0, 0, 1, 1, 32'h0000_3000);
    check("jr_prio_back", pc, 32'h0000_3000);

    // j at 0x3000
    fetch(32'h0800_0C04);
    check("link_val", pc_plus4, 32'h0000_3004);
    retire(0, 0, 1, 0, 32'h0);
    check("j_target", pc, 32'h0000_3010);

    // beq taken, imm -2
    fetch(32'h1000_FFFE);
    retire(1, 1, 0, 0, 32'h0);
    check("beq_taken", pc, 32'h0000_300C);
    fetch(32'h0800_0C04);
    retire(0, 0, 1, 1, 32'h0000_3010);
    check("jr_3010", pc, 32'h0000_3010);
    fetch(32'h1000_FFFE);
    retire(1, 0, 0, 0, 32'h0);
    check("beq_not_taken", pc, 32'h0000_3014);

    fetch(32'h0800_0C04);
    retire(0, 0, 1, 1, 32'h0000_3020);
    check("jr_3020", pc, 32'h0000_3020);

    // ack delayed 5 cycles, stray instr_done during REQ
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (imem_req) cnt++;
      check("addr_stable", imem_addr, 32'h0000_3020);
      instr_done = (i == 2);
      imem_ack   = (i == 5);
      imem_rdata = 32'h0000_0020;
      tick();
    end
    imem_ack = 1'b0; instr_done = 1'b0;
    check("req_cycles", cnt, 32'd6);
    check("delayed_valid", {31'd0, instr_valid}, 32'd1);
    check("done_in_req_ignored", pc, 32'h0000_3020);
    retire(0, 0, 0, 0, 32'h0);
    check("pc_3024", pc, 32'h0000_3024);

    // reset mid-REQ; acks during and right after reset are discarded
    rst = 1'b1; imem_rdata = 32'hDEAD_BEEF; imem_ack = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    imem_ack = 1'b0;
    check("midrst_pc", pc, 32'h0000_3000);
    check("midrst_instr", instr, 32'h0);
    check("midrst_valid", {31'd0, instr_valid}, 32'd0);
    check("midrst_req", {31'd0, imem_req}, 32'd1);

    // PC wrap-around
    fetch(32'h0000_0000);
    retire(0, 0, 1, 1, 32'hFFFF_FFFC);
    check("pc_top", pc, 32'hFFFF_FFFC);
    fetch(32'h0000_0000);
    check("plus4_wrap", pc_plus4, 32'h0);
    retire(0, 0, 0, 0, 32'h0);
    check("pc_wrap", pc, 32'h0);

    // misaligned jr target
    fetch(32'h0000_0008);
    retire(0, 0, 1, 1, 32'h0000_3022);
`ifdef IFU_ALIGN_CHECK_EN
    tick(); tick(); tick();
    check("fault_set", {31'd0, fault}, 32'd1);
    check("fault_req", {31'd0, imem_req}, 32'd0);
    check("fault_pc", pc, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("fault_cleared", {31'd0, fault}, 32'd0);
`else
    check("align_forced", pc, 32'h0000_3020);
    check("no_fault", {31'd0, fault}, 32'd0);
    check("req_after_jr", {31'd0, imem_req}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
